// File: rtl/i_sram_loader.sv
// i_sram_loader: gathers CHUNKS narrow input chunks into one wide SRAM line
// and writes consecutive lines starting at a base address, wrapping at DEPTH.
module i_sram_loader #(
    parameter int DEPTH   = 200,
    parameter int CHUNK_W = 48,
    parameter int CHUNKS  = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 base_addr,
    input  logic [7:0]                 line_count,
    input  logic                       in_valid,
    input  logic [CHUNK_W-1:0]         in_data,
    output logic                       in_ready,
    output logic                       WE,
    output logic [7:0]                 WriteAddress,
    output logic [CHUNK_W*CHUNKS-1:0]  WriteBus,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int              LineW     = CHUNK_W * CHUNKS;
    localparam int              CntW      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CntW-1:0] LastChunk = CntW'(CHUNKS - 1);
    localparam logic [8:0]      DepthLim  = 9'(DEPTH);
    localparam logic [7:0]      LastAddr  = 8'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } stateT;

    stateT           state;
    stateT           nextState;
    logic [CntW-1:0] chunkCnt;
    logic [7:0]      curAddr;
    logic [7:0]      linesLeft;
    logic [LineW-1:0] lineBuf;
    logic [LineW-1:0] nextLine;
    logic            addrOk;
    logic            chunkXfer;

    // Qualify the start request and detect a chunk handshake in FILL.
    always_comb begin
        addrOk    = ({1'b0, base_addr} < DepthLim);
        chunkXfer = (state == FILL) && in_valid;
    end

    // Line image including the chunk arriving this cycle, chunk 0 in the LSBs.
    always_comb begin
        nextLine = lineBuf;
        for (int k = 0; k < CHUNKS; k++) begin
            if (chunkCnt == CntW'(k)) begin
                nextLine[k*CHUNK_W +: CHUNK_W] = in_data;
            end
        end
    end

    // State register; reset wins over every request and handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode plus the status outputs that follow the state directly.
    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start && addrOk) begin
                    nextState = (line_count == 8'd0) ? DONE : FILL;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (chunkCnt == LastChunk)) begin
                    nextState = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                nextState = (linesLeft == 8'd1) ? DONE : FILL;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: load parameters, collect chunks, launch the registered write
    // on the last chunk so WE is high exactly during WRITE, then advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            chunkCnt     <= '0;
            curAddr      <= 8'd0;
            linesLeft    <= 8'd0;
            lineBuf      <= '0;
            WE           <= 1'b0;
            WriteAddress <= 8'd0;
            WriteBus     <= '0;
            error        <= 1'b0;
        end else begin
            WE    <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!addrOk) begin
                            error <= 1'b1;
                        end else begin
                            curAddr   <= base_addr;
                            linesLeft <= line_count;
                            chunkCnt  <= '0;
                        end
                    end
                end
                FILL: begin
                    if (chunkXfer) begin
                        lineBuf <= nextLine;
                        if (chunkCnt == LastChunk) begin
                            chunkCnt     <= '0;
                            WE           <= 1'b1;
                            WriteAddress <= curAddr;
                            WriteBus     <= nextLine;
                        end else begin
                            chunkCnt <= chunkCnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    curAddr   <= (curAddr == LastAddr) ? 8'd0 : curAddr + 8'd1;
                    linesLeft <= linesLeft - 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i_sram_loader.sv
// tb_i_sram_loader: randomized bench with a line-level reference model and a
// scoreboard that pairs every observed SRAM write with a predicted one.
module tb_i_sram_loader;

    localparam int DEPTH   = 200;
    localparam int CHUNK_W = 48;
    localparam int CHUNKS  = 5;
    localparam int LINE_W  = CHUNK_W * CHUNKS;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic [7:0]         base_addr;
    logic [7:0]         line_count;
    logic               in_valid;
    logic [CHUNK_W-1:0] in_data;
    logic               in_ready;
    logic               WE;
    logic [7:0]         WriteAddress;
    logic [LINE_W-1:0]  WriteBus;
    logic               busy;
    logic               done;
    logic               error;

    typedef struct {
        logic [7:0]        addr;
        logic [LINE_W-1:0] data;
    } wrT;

    wrT                expQ[$];
    int                checks = 0;
    int                errors = 0;
    int                weCount = 0;
    int                doneCount = 0;
    int                errCount = 0;
    int                expDone = 0;
    int                expErr = 0;
    int                hsSinceWrite = 0;
    time               lastWeTime = 0;
    time               doneTime = 0;
    time               acceptTime = 0;
    logic [LINE_W-1:0] presetLine;

    i_sram_loader #(
        .DEPTH  (DEPTH),
        .CHUNK_W(CHUNK_W),
        .CHUNKS (CHUNKS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .line_count  (line_count),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .WE          (WE),
        .WriteAddress(WriteAddress),
        .WriteBus    (WriteBus),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Monitor: on every falling edge pop the predicted write when WE is seen,
    // and count done/error pulses for the sequencing checks.
    always @(negedge clock) begin : monitor
        wrT expWr;
        if (WE === 1'b1) begin
            weCount++;
            lastWeTime = $time;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWE", LINE_W'(1), LINE_W'(0));
            end else begin
                expWr = expQ.pop_front();
                checkOutput("writeAddr", LINE_W'(WriteAddress), LINE_W'(expWr.addr));
                checkOutput("writeBus", WriteBus, expWr.data);
                checkOutput("handshakesPerLine", LINE_W'(hsSinceWrite), LINE_W'(CHUNKS));
            end
            hsSinceWrite = 0;
        end
        if (done === 1'b1) begin
            doneCount++;
            doneTime = $time;
        end
        if (error === 1'b1) begin
            errCount++;
        end
    end

    task automatic startLoad(input logic [7:0] b, input logic [7:0] c);
        @(negedge clock);
        start      = 1'b1;
        base_addr  = b;
        line_count = c;
        @(posedge clock);
        acceptTime = $time;
        #1 start = 1'b0;
    endtask

    task automatic feedLine(input logic [LINE_W-1:0] line, input int prob,
                            input bit chaos, input int nChunks);
        for (int k = 0; k < nChunks; k++) begin
            bit   sent;
            int   guard;
            logic rdy;
            sent  = 1'b0;
            guard = 0;
            while (!sent && guard < 2000) begin
                @(negedge clock);
                in_valid = (int'($urandom_range(100, 1)) <= prob);
                in_data  = in_valid ? line[k*CHUNK_W +: CHUNK_W]
                                    : CHUNK_W'({$urandom, $urandom});
                if (chaos) begin
                    start      = 1'($urandom_range(0, 1));
                    base_addr  = 8'($urandom);
                    line_count = 8'($urandom);
                end
                rdy = in_ready;
                @(posedge clock);
                if (in_valid && rdy) begin
                    sent = 1'b1;
                    hsSinceWrite++;
                end
                guard++;
            end
            if (!sent) begin
                checkOutput("chunkTimeout", LINE_W'(0), LINE_W'(1));
                return;
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Reference model: a load of c lines from b writes line i to (b+i) mod DEPTH,
    // each line being its chunks laid out from the LSB upward.
    task automatic applyStimulus(input logic [7:0] b, input logic [7:0] c, input int prob,
                                 input bit chaos, input int mode);
        startLoad(b, c);
        if (int'(b) >= DEPTH) begin
            expErr++;
            return;
        end
        expDone++;
        for (int i = 0; i < int'(c); i++) begin
            wrT                e;
            logic [LINE_W-1:0] line;
            for (int k = 0; k < CHUNKS; k++) begin
                line[k*CHUNK_W +: CHUNK_W] = (mode == 1) ? CHUNK_W'(k + 1)
                                                         : CHUNK_W'({$urandom, $urandom});
            end
            if (mode == 2) line = presetLine;
            e.addr = 8'((int'(b) + i) % DEPTH);
            e.data = line;
            expQ.push_back(e);
            feedLine(line, prob, chaos, CHUNKS);
        end
    endtask

    task automatic waitDone();
        int guard;
        guard = 0;
        while (doneCount < expDone && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (doneCount < expDone) begin
            checkOutput("doneTimeout", LINE_W'(doneCount), LINE_W'(expDone));
        end
        repeat (2) @(negedge clock);
    endtask

    // Main sequence of directed and randomized loads.
    initial begin
        int weB;
        int dB;
        int eB;
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = 8'd0;
        line_count = 8'd0;
        in_valid   = 1'b0;
        in_data    = '0;
        presetLine = '0;

        repeat (3) @(negedge clock);
        checkOutput("resetWE", LINE_W'(WE), LINE_W'(0));
        checkOutput("resetAddr", LINE_W'(WriteAddress), LINE_W'(0));
        checkOutput("resetBus", WriteBus, LINE_W'(0));
        checkOutput("resetBusy", LINE_W'(busy), LINE_W'(0));
        checkOutput("resetDone", LINE_W'(done), LINE_W'(0));
        checkOutput("resetError", LINE_W'(error), LINE_W'(0));
        checkOutput("resetReady", LINE_W'(in_ready), LINE_W'(0));
        reset = 1'b0;
        repeat (2) @(negedge clock);

        weB = weCount;
        dB  = doneCount;
        applyStimulus(8'd10, 8'd1, 100, 1'b0, 1);
        waitDone();
        checkOutput("firstWeLatency", LINE_W'(lastWeTime + 5 - acceptTime), LINE_W'(60));
        checkOutput("doneAfterWe", LINE_W'(doneTime - lastWeTime), LINE_W'(10));
        checkOutput("singleLineWeCount", LINE_W'(weCount - weB), LINE_W'(1));
        checkOutput("singleLineDoneCount", LINE_W'(doneCount - dB), LINE_W'(1));
        checkOutput("holdAddr", LINE_W'(WriteAddress), LINE_W'(10));
        checkOutput("holdBus", WriteBus,
                    {48'h5, 48'h4, 48'h3, 48'h2, 48'h1});

        weB = weCount;
        dB  = doneCount;
        applyStimulus(8'd198, 8'd3, 100, 1'b0, 0);
        waitDone();
        checkOutput("wrapWeCount", LINE_W'(weCount - weB), LINE_W'(3));
        checkOutput("wrapDoneCount", LINE_W'(doneCount - dB), LINE_W'(1));

        weB = weCount;
        eB  = errCount;
        applyStimulus(8'd200, 8'd1, 100, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checkOutput("busyOnError", LINE_W'(busy), LINE_W'(0));
        end
        checkOutput("errorPulseCount", LINE_W'(errCount - eB), LINE_W'(1));
        checkOutput("errorNoWrite", LINE_W'(weCount - weB), LINE_W'(0));

        weB = weCount;
        dB  = doneCount;
        applyStimulus(8'd20, 8'd0, 100, 1'b0, 0);
        waitDone();
        checkOutput("zeroLinesDoneTime", LINE_W'(doneTime - acceptTime), LINE_W'(5));
        checkOutput("zeroLinesNoWrite", LINE_W'(weCount - weB), LINE_W'(0));
        checkOutput("zeroLinesDoneCount", LINE_W'(doneCount - dB), LINE_W'(1));

        for (int n = 0; n < 6; n++) begin
            applyStimulus(8'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(1, 4)),
                          50, 1'b1, 0);
            waitDone();
        end

        presetLine = {$urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom};
        weB = weCount;
        dB  = doneCount;
        startLoad(8'd50, 8'd1);
        feedLine(presetLine, 100, 1'b0, 3);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midResetWE", LINE_W'(WE), LINE_W'(0));
        checkOutput("midResetAddr", LINE_W'(WriteAddress), LINE_W'(0));
        checkOutput("midResetBus", WriteBus, LINE_W'(0));
        checkOutput("midResetBusy", LINE_W'(busy), LINE_W'(0));
        checkOutput("midResetDone", LINE_W'(done), LINE_W'(0));
        checkOutput("midResetError", LINE_W'(error), LINE_W'(0));
        checkOutput("midResetReady", LINE_W'(in_ready), LINE_W'(0));
        reset        = 1'b0;
        hsSinceWrite = 0;
        repeat (5) @(negedge clock);
        checkOutput("abortNoWrite", LINE_W'(weCount - weB), LINE_W'(0));
        checkOutput("abortNoDone", LINE_W'(doneCount - dB), LINE_W'(0));
        applyStimulus(8'd50, 8'd1, 100, 1'b0, 2);
        waitDone();
        checkOutput("rebuildWeCount", LINE_W'(weCount - weB), LINE_W'(1));

        weB = weCount;
        applyStimulus(8'd150, 8'd202, 100, 1'b0, 0);
        waitDone();
        checkOutput("longWrapWeCount", LINE_W'(weCount - weB), LINE_W'(202));

        checkOutput("pendingWrites", LINE_W'(expQ.size()), LINE_W'(0));
        checkOutput("totalDone", LINE_W'(doneCount), LINE_W'(expDone));
        checkOutput("totalError", LINE_W'(errCount), LINE_W'(expErr));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i_sram_loader.md
I_SRAM_LOADER -- requirements
Module: i_sram_loader

Interface
REQ-001 The module SHALL expose parameter DEPTH, default 200, the number of SRAM lines.
REQ-002 The module SHALL expose parameter CHUNK_W, default 48, the input chunk width in bits.
REQ-003 The module SHALL expose parameter CHUNKS, default 5, the chunks per line; the line width is CHUNK_W*CHUNKS = 240 bits.
REQ-004 The module SHALL have port clock, input, 1 bit, the single clock.
REQ-005 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 The module SHALL have port start, input, 1 bit, a one-cycle request to begin a load.
REQ-007 The module SHALL have port base_addr, input, 8 bits, the first line to write, sampled when start is accepted.
REQ-008 The module SHALL have port line_count, input, 8 bits, the number of lines to write, sampled when start is accepted.
REQ-009 The module SHALL have port in_valid, input, 1 bit, marking that in_data holds a valid chunk.
REQ-010 The module SHALL have port in_data, input, CHUNK_W bits, the chunk payload.
REQ-011 The module SHALL have port in_ready, output, 1 bit, the chunk-accept indicator.
REQ-012 The module SHALL have port WE, output, 1 bit, the SRAM write enable.
REQ-013 The module SHALL have port WriteAddress, output, 8 bits, the SRAM write line address.
REQ-014 The module SHALL have port WriteBus, output, 240 bits, the SRAM write data.
REQ-015 The module SHALL have port busy, output, 1 bit, high while a load is in progress.
REQ-016 The module SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-017 The module SHALL have port error, output, 1 bit, a one-cycle pulse for a rejected start.

Function
REQ-018 The module SHALL implement the states IDLE, FILL, WRITE and DONE.
REQ-019 In IDLE, start=1 with base_addr<DEPTH and line_count>0 SHALL latch cur_addr=base_addr and lines_left=line_count, clear chunk_cnt, and go to FILL on the next cycle.
REQ-020 In IDLE, start=1 with base_addr>=DEPTH SHALL pulse error for 1 cycle, perform no write, and stay in IDLE.
REQ-021 In IDLE, start=1 with base_addr<DEPTH and line_count=0 SHALL go to DONE with no write.
REQ-022 A start asserted while not in IDLE SHALL be ignored.
REQ-023 in_ready SHALL be 1 only in FILL.
REQ-024 A chunk SHALL transfer on a rising clock edge when in_valid=1 and in_ready=1.
REQ-025 Chunk k (k=0..CHUNKS-1) SHALL be stored in line bits [CHUNK_W*k+CHUNK_W-1 : CHUNK_W*k], so chunk 0 lands in the LSBs.
REQ-026 On acceptance of chunk CHUNKS-1, the module SHALL go to WRITE; in_valid=0 SHALL stall FILL indefinitely with no timeout.
REQ-027 In WRITE, WE SHALL be 1 for exactly 1 cycle, with WriteAddress=cur_addr and WriteBus equal to the assembled line; WE, WriteAddress and WriteBus SHALL be registered outputs.
REQ-028 After WRITE, the module SHALL update cur_addr to (cur_addr==DEPTH-1) ? 0 : cur_addr+1 and decrement lines_left.
REQ-029 After WRITE, the module SHALL go to DONE if lines_left becomes 0, else return to FILL with chunk_cnt=0.
REQ-030 In DONE, done SHALL be 1 for 1 cycle, after which the module SHALL return to IDLE.
REQ-031 busy SHALL be 1 in FILL and WRITE, and 0 in IDLE and DONE.
REQ-032 Minimum throughput SHALL be CHUNKS+1 = 6 cycles per line with in_valid held at 1.
REQ-033 The first WE SHALL occur 6 cycles after the start-accept edge when in_valid=1 continuously.
REQ-034 WE SHALL be 0 outside WRITE, and WriteAddress/WriteBus SHALL hold their last values when WE=0.
REQ-035 line_count>DEPTH SHALL be legal; the address SHALL wrap and lines SHALL be overwritten in order.

Reset
REQ-036 When reset=1 at a clock edge, the module SHALL force state IDLE.
REQ-037 When reset=1 at a clock edge, the module SHALL clear in_ready, WE, busy, done and error to 0.
REQ-038 When reset=1 at a clock edge, the module SHALL clear WriteAddress=0, WriteBus=0, chunk_cnt=0, cur_addr=0 and lines_left=0.
REQ-039 Reset SHALL take priority over start and over all handshakes.
REQ-040 Reset asserted mid-load SHALL discard the partial line with no further WE, and SHALL NOT pulse done.

Verification
REQ-041 The bench SHALL drive base_addr=10, line_count=1, and chunks 0x1..0x5 with in_valid held at 1, and SHALL check one WE pulse at address 10 with WriteBus={48'h5,48'h4,48'h3,48'h2,48'h1}, followed by done one cycle later.
REQ-042 The bench SHALL drive base_addr=198, line_count=3, and SHALL check writes to addresses 198, 199 and 0, with exactly one done pulse.
REQ-043 The bench SHALL drive base_addr=200 and SHALL check an error pulse for 1 cycle, no WE, and busy=0 throughout.
REQ-044 The bench SHALL drive line_count=0 and SHALL check done one cycle after start, with no WE.
REQ-045 The bench SHALL toggle in_valid randomly and SHALL check that no chunk is lost or duplicated and that WE only follows 5 handshakes.
REQ-046 The bench SHALL assert reset after 3 chunks of a line and SHALL check no WE, no done, and all outputs at 0; a subsequent start SHALL rebuild that line from chunk 0.
